// File: rtl/bist_pkg.sv
// Shared types and the Galois step used by both the stimulus LFSR and the
// response MISR of the s27 self-test driver.
package bist_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_INIT,
      ST_RUN,
      ST_DRAIN,
      ST_DONE
   } state_t;

   // x^8 + x^4 + x^3 + x^2 + 1
   localparam logic [7:0] POLY8 = 8'h1D;

   function automatic logic [7:0] galois8_step(input logic [7:0] value,
                                               input logic [7:0] in);
      return {value[6:0], 1'b0} ^ (value[7] ? POLY8 : 8'h00) ^ in;
   endfunction

endpackage

// File: rtl/galois_reg8.sv
// 8-bit Galois shift register with seed load, step enable and parallel XOR
// input; serves as LFSR (in tied to zero) or as MISR.
module galois_reg8
   import bist_pkg::*;
#(
   parameter logic [7:0] RST_VAL = 8'h00
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       load_i,
   input  logic [7:0] seed_i,
   input  logic       en_i,
   input  logic [7:0] in_i,
   output logic [7:0] q_o
);

   logic [7:0] q_q;
   logic [7:0] q_d;

   // Seed load wins over a step so a restart never folds in a stale sample.
   always_comb begin
      q_d = q_q;
      if (load_i) begin
         q_d = seed_i;
      end else if (en_i) begin
         q_d = galois8_step(q_q, in_i);
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         q_q <= RST_VAL;
      end else begin
         q_q <= q_d;
      end
   end

   assign q_o = q_q;

endmodule

// File: rtl/bist_s27_driver.sv
// Self-test driver for the s27 benchmark: flush, LFSR pattern phase and
// latency drain, with MISR compaction of the response and golden compare.
module bist_s27_driver
   import bist_pkg::*;
#(
   parameter int unsigned         N_IN      = 4,
   parameter int unsigned         N_OUT     = 1,
   parameter logic [7:0]          LFSR_SEED = 8'h01,
   parameter int unsigned         PATTERNS  = 255,
   parameter int unsigned         INIT_CYC  = 4,
   parameter logic [N_IN-1:0]     INIT_VEC  = '0,
   parameter int unsigned         LAT       = 0,
   parameter logic [7:0]          MISR_SEED = 8'h00,
   parameter logic [7:0]          GOLDEN    = 8'h00
) (
   input  logic              CK,
   input  logic              RST,
   input  logic              START,
   output logic [N_IN-1:0]   DUT_IN,
   input  logic [N_OUT-1:0]  DUT_OUT,
   output logic              BUSY,
   output logic              DONE,
   output logic              PASS,
   output logic [7:0]        SIGNATURE,
   output logic [15:0]       PAT_CNT
);

   localparam logic [7:0]  SEED_EFF  = (LFSR_SEED == 8'h00) ? 8'h01 : LFSR_SEED;
   localparam int unsigned SR_W      = (LAT > 0) ? LAT : 1;
   localparam logic [15:0] PAT_MAX   = 16'(PATTERNS);
   localparam logic [15:0] PAT_LAST  = 16'(PATTERNS - 1);
   localparam logic [7:0]  INIT_LAST = 8'(INIT_CYC - 1);
   localparam logic [7:0]  LAT_LAST  = 8'(LAT - 1);

   function automatic logic [15:0] sat_inc(input logic [15:0] cnt);
      return (cnt >= PAT_MAX) ? cnt : cnt + 16'd1;
   endfunction

   state_t            state_q, state_d;
   logic [N_IN-1:0]   dut_in_q, dut_in_d;
   logic [15:0]       pat_cnt_q, pat_cnt_d;
   logic [7:0]        cyc_cnt_q, cyc_cnt_d;
   logic [SR_W-1:0]   run_sr_q, run_sr_d;
   logic              seed_load;
   logic              lfsr_en;
   logic              cap_en;
   logic [7:0]        lfsr_q;
   logic [7:0]        lfsr_nxt;
   logic [7:0]        misr_q;
   logic [7:0]        misr_in;
   logic              unused_lfsr_hi;

   assign lfsr_nxt       = galois8_step(lfsr_q, 8'h00);
   assign unused_lfsr_hi = ^{lfsr_q, lfsr_nxt};

   // The RUN-flag pipe lines each response up with the pattern that caused it.
   assign cap_en = (LAT == 0) ? (state_q == ST_RUN) : run_sr_q[SR_W-1];

   always_comb begin
      misr_in              = '0;
      misr_in[N_OUT-1:0]   = DUT_OUT;
   end

   always_comb begin
      state_d   = state_q;
      dut_in_d  = dut_in_q;
      pat_cnt_d = pat_cnt_q;
      cyc_cnt_d = cyc_cnt_q;
      run_sr_d  = (run_sr_q << 1) | SR_W'(state_q == ST_RUN);
      seed_load = 1'b0;
      lfsr_en   = 1'b0;
      unique case (state_q)
         ST_IDLE, ST_DONE: begin
            if (START) begin
               seed_load = 1'b1;
               pat_cnt_d = '0;
               cyc_cnt_d = '0;
               run_sr_d  = '0;
               if (INIT_CYC == 0) begin
                  state_d  = ST_RUN;
                  dut_in_d = SEED_EFF[N_IN-1:0];
               end else begin
                  state_d  = ST_INIT;
                  dut_in_d = INIT_VEC;
               end
            end
         end
         ST_INIT: begin
            if (cyc_cnt_q == INIT_LAST) begin
               state_d   = ST_RUN;
               cyc_cnt_d = '0;
               dut_in_d  = lfsr_q[N_IN-1:0];
            end else begin
               cyc_cnt_d = cyc_cnt_q + 8'd1;
            end
         end
         ST_RUN: begin
            lfsr_en   = 1'b1;
            pat_cnt_d = sat_inc(pat_cnt_q);
            dut_in_d  = lfsr_nxt[N_IN-1:0];
            if (pat_cnt_q == PAT_LAST) begin
               dut_in_d  = dut_in_q;
               cyc_cnt_d = '0;
               state_d   = (LAT == 0) ? ST_DONE : ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if (cyc_cnt_q == LAT_LAST) begin
               state_d = ST_DONE;
            end else begin
               cyc_cnt_d = cyc_cnt_q + 8'd1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge CK or posedge RST) begin
      if (RST) begin
         state_q   <= ST_IDLE;
         dut_in_q  <= INIT_VEC;
         pat_cnt_q <= '0;
         cyc_cnt_q <= '0;
         run_sr_q  <= '0;
      end else begin
         state_q   <= state_d;
         dut_in_q  <= dut_in_d;
         pat_cnt_q <= pat_cnt_d;
         cyc_cnt_q <= cyc_cnt_d;
         run_sr_q  <= run_sr_d;
      end
   end

   galois_reg8 #(.RST_VAL(SEED_EFF)) u_lfsr (
      .clk_i  (CK),
      .rst_i  (RST),
      .load_i (seed_load),
      .seed_i (SEED_EFF),
      .en_i   (lfsr_en),
      .in_i   (8'h00),
      .q_o    (lfsr_q)
   );

   galois_reg8 #(.RST_VAL(MISR_SEED)) u_misr (
      .clk_i  (CK),
      .rst_i  (RST),
      .load_i (seed_load),
      .seed_i (MISR_SEED),
      .en_i   (cap_en),
      .in_i   (misr_in),
      .q_o    (misr_q)
   );

   assign DUT_IN    = dut_in_q;
   assign BUSY      = (state_q == ST_INIT) || (state_q == ST_RUN) || (state_q == ST_DRAIN);
   assign DONE      = (state_q == ST_DONE);
   assign PASS      = (state_q == ST_DONE) && (misr_q == GOLDEN);
   assign SIGNATURE = misr_q;
   assign PAT_CNT   = pat_cnt_q;

endmodule
